ascii_uart_tx: RTL and testbench

Serial output stage directly downstream of the binary-to-ASCII converter. Captures the converter's 8-character, 7-bit ASCII string when its `ready` rises (conversion done) and transmits it over an 8N1 UART line, most-significant digit first, optionally followed by CR LF. Gives the converter's result a path to a terminal without CPU involvement.

---
 rtl/bin2ascii_pkg.sv | 21 ++
 rtl/uart_baud_gen.sv | 28 ++
 rtl/ascii_uart_tx.sv | 134 +++++++++++++
 tb/tb_ascii_uart_tx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2ascii_pkg.sv
// rtl/bin2ascii_pkg.sv - shared constants, tx state type and baud divider helper
package bin2ascii_pkg;

  localparam logic [6:0] ZERO  = 7'd48;
  localparam logic [6:0] SPACE = 7'd32;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // Clock cycles per UART bit, rounded to nearest
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - DIV-cycle bit tick counter with synchronous clear
module uart_baud_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ascii_uart_tx.sv
// rtl/ascii_uart_tx.sv - sends the converter's 8-char ASCII string over 8N1 UART
module ascii_uart_tx
  import bin2ascii_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int SEND_CRLF = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [55:0] asciiinput,
  input  logic        conv_ready,
  output logic        txd,
  output logic        busy,
  output logic        overrun
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int N   = (SEND_CRLF != 0) ? 10 : 8;

  if (DIV < 2) begin : g_bad_div
    $error("ascii_uart_tx: CLK_HZ/BAUD gives a bit divider below 2");
  end

  tx_state_e   state_q, state_d;
  logic        prev_ready;
  logic        edge_det;
  logic [55:0] shadow_q, shadow_d;
  logic [3:0]  char_idx_q, char_idx_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  byte_q, byte_d;
  logic        txd_q, txd_d;
  logic        busy_q;
  logic        overrun_q;
  logic        tick, baud_clr;

  // Chars 0..7 come from the shadow string, 8 and 9 are the line terminator
  function automatic logic [7:0] char_byte(input logic [55:0] sh, input logic [3:0] idx);
    logic [55:0] s;
    s = sh << (7 * idx);
    if (idx < 4'd8)       return {1'b0, s[55:49]};
    else if (idx == 4'd8) return CR;
    else                  return LF;
  endfunction

  assign edge_det = conv_ready & ~prev_ready;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (baud_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    char_idx_d = char_idx_q;
    bit_idx_d  = bit_idx_q;
    byte_d     = byte_q;
    case (state_q)
      TX_IDLE: begin
        if (edge_det) begin
          shadow_d   = asciiinput;
          char_idx_d = 4'd0;
          byte_d     = {1'b0, asciiinput[55:49]};
          state_d    = TX_START;
        end
      end
      TX_START: begin
        if (tick) begin
          bit_idx_d = 3'd0;
          state_d   = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) state_d = TX_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (char_idx_q < 4'(N - 1)) begin
            char_idx_d = char_idx_q + 4'd1;
            byte_d     = char_byte(shadow_q, char_idx_q + 4'd1);
            state_d    = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // Line level is registered from next-state values so txd is glitch-free
    case (state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = byte_d[bit_idx_d];
      default:  txd_d = 1'b1;
    endcase

    baud_clr = (state_d != state_q) || (state_q == TX_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TX_IDLE;
      prev_ready <= 1'b1;
      shadow_q   <= '0;
      char_idx_q <= '0;
      bit_idx_q  <= '0;
      byte_q     <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_ready <= conv_ready;
      shadow_q   <= shadow_d;
      char_idx_q <= char_idx_d;
      bit_idx_q  <= bit_idx_d;
      byte_q     <= byte_d;
      txd_q      <= txd_d;
      busy_q     <= (state_d != TX_IDLE);
      if (edge_det && (state_q != TX_IDLE)) overrun_q <= 1'b1;
    end
  end

  assign txd     = txd_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_ascii_uart_tx.sv
// tb/tb_ascii_uart_tx.sv - scoreboard bench for ascii_uart_tx with UART line decoders
module tb_ascii_uart_tx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [55:0] ascii1, ascii0;
  logic        rdy1, rdy0;
  logic        txd1, txd0, busy1, busy0, ovr1, ovr0;

  always #5 clk = ~clk;

  ascii_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .SEND_CRLF(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .asciiinput(ascii1), .conv_ready(rdy1),
    .txd(txd1), .busy(busy1), .overrun(ovr1)
  );

  ascii_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .SEND_CRLF(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .asciiinput(ascii0), .conv_ready(rdy0),
    .txd(txd0), .busy(busy0), .overrun(ovr0)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q1[$];
  logic [7:0] exp_q0[$];
  int         blen_q1[$];
  int         blen_q0[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic get_txd(input int ch);
    return (ch != 0) ? txd1 : txd0;
  endfunction

  function automatic logic get_busy(input int ch);
    return (ch != 0) ? busy1 : busy0;
  endfunction

  function automatic logic [55:0] rand_str();
    logic [55:0] s;
    for (int i = 0; i < 8; i++) s[55-7*i -: 7] = 7'($urandom_range(0, 127));
    return s;
  endfunction

  // Reference: message = the 8 captured chars, then CR LF on the CRLF channel
  task automatic push_exp(input int ch, input logic [55:0] s);
    for (int i = 0; i < 8; i++) begin
      if (ch != 0) exp_q1.push_back({1'b0, s[55-7*i -: 7]});
      else         exp_q0.push_back({1'b0, s[55-7*i -: 7]});
    end
    if (ch != 0) begin
      exp_q1.push_back(8'h0D);
      exp_q1.push_back(8'h0A);
      blen_q1.push_back(10 * DIV * 10);
    end else begin
      blen_q0.push_back(10 * DIV * 8);
    end
  endtask

  task automatic uart_mon(input int ch);
    logic [7:0] b;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst_n && get_txd(ch) == 1'b0) begin
        aborted = 0;
        repeat (DIV/2 - 1) @(negedge clk);
        if (!rst_n) aborted = 1;
        else check($sformatf("start_bit ch%0d", ch), get_txd(ch), 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          if (!rst_n) aborted = 1;
          b[i] = get_txd(ch);
        end
        repeat (DIV) @(negedge clk);
        if (!rst_n) aborted = 1;
        if (!aborted) begin
          check($sformatf("stop_bit ch%0d", ch), get_txd(ch), 1'b1);
          if ((ch != 0 && exp_q1.size() == 0) || (ch == 0 && exp_q0.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte ch%0d: got %02h expected none", ch, b);
          end else if (ch != 0) begin
            check("rx_byte ch1", b, exp_q1.pop_front());
          end else begin
            check("rx_byte ch0", b, exp_q0.pop_front());
          end
        end
      end
    end
  endtask

  task automatic busy_mon(input int ch);
    int n;
    bit ab;
    forever begin
      @(negedge clk);
      if (get_busy(ch)) begin
        n  = 0;
        ab = 0;
        while (get_busy(ch)) begin
          n++;
          if (!rst_n) ab = 1;
          @(negedge clk);
        end
        if (!rst_n) ab = 1;
        if (!ab) begin
          if ((ch != 0 && blen_q1.size() == 0) || (ch == 0 && blen_q0.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_busy ch%0d: got run of %0d expected none", ch, n);
          end else if (ch != 0) begin
            check("busy_len ch1", 64'(n), 64'(blen_q1.pop_front()));
          end else begin
            check("busy_len ch0", 64'(n), 64'(blen_q0.pop_front()));
          end
        end
      end
    end
  endtask

  task automatic wait_idle(input int ch);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (get_busy(ch) && n < 20000);
    if (n >= 20000) begin
      checks++;
      failures++;
      $display("FAIL wait_idle ch%0d: busy still 1 after %0d cycles, required 0", ch, n);
    end
  endtask

  task automatic send(input int ch, input logic [55:0] s);
    push_exp(ch, s);
    @(negedge clk);
    if (ch != 0) begin ascii1 = s; rdy1 = 1'b1; end
    else         begin ascii0 = s; rdy0 = 1'b1; end
    @(negedge clk);
    if (ch != 0) rdy1 = 1'b0;
    else         rdy0 = 1'b0;
    wait_idle(ch);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [55:0] s;
    bit          seen;

    rst_n  = 1'b0;
    rdy1   = 1'b0;
    rdy0   = 1'b0;
    ascii1 = '0;
    ascii0 = '0;
    repeat (3) @(negedge clk);
    check("reset txd1", txd1, 1'b1);
    check("reset busy1", busy1, 1'b0);
    check("reset ovr1", ovr1, 1'b0);
    check("reset txd0", txd0, 1'b1);
    check("reset busy0", busy0, 1'b0);
    check("reset ovr0", ovr0, 1'b0);
    rst_n = 1'b1;

    fork
      uart_mon(1);
      uart_mon(0);
      busy_mon(1);
      busy_mon(0);
    join_none

    repeat (3) @(negedge clk);
    send(1, {7'h20, 7'h20, 7'h31, 7'h32, 7'h33, 7'h34, 7'h35, 7'h36});
    repeat (3) send(1, rand_str());
    send(0, {8{7'h39}});
    repeat (2) send(0, rand_str());

    // Edge one cycle after the final stop is accepted; edge on the final stop is an overrun
    s = rand_str();
    push_exp(1, s);
    @(negedge clk);
    ascii1 = s; rdy1 = 1'b1;
    @(negedge clk);
    rdy1 = 1'b0;
    repeat (1000) @(negedge clk);
    s = rand_str();
    push_exp(1, s);
    ascii1 = s; rdy1 = 1'b1;
    repeat (2) @(negedge clk);
    check("late_edge_no_overrun", ovr1, 1'b0);
    check("late_edge_busy", busy1, 1'b1);
    rdy1 = 1'b0;
    repeat (998) @(negedge clk);
    ascii1 = rand_str(); rdy1 = 1'b1;
    @(negedge clk);
    check("coincident_overrun", ovr1, 1'b1);
    check("coincident_not_sent", busy1, 1'b0);
    rdy1 = 1'b0;
    repeat (5) @(negedge clk);
    check("coincident_idle", busy1, 1'b0);

    // Reset in the middle of the third character's data bits
    s = rand_str();
    push_exp(1, s);
    ascii1 = s; rdy1 = 1'b1;
    repeat (250) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset txd1", txd1, 1'b1);
    check("async_reset busy1", busy1, 1'b0);
    check("async_reset ovr1", ovr1, 1'b0);
    repeat (20) @(negedge clk);
    exp_q1.delete();
    blen_q1.delete();
    rst_n = 1'b1;
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (busy1) seen = 1;
    end
    check("held_ready_no_tx", seen, 1'b0);
    rdy1 = 1'b0;
    @(negedge clk);

    // Input string churns every cycle after capture
    s = rand_str();
    push_exp(1, s);
    ascii1 = s; rdy1 = 1'b1;
    @(negedge clk);
    rdy1 = 1'b0;
    repeat (1010) begin
      ascii1 = 56'({$urandom(), $urandom()});
      @(negedge clk);
    end
    wait_idle(1);

    // Second edge 300 cycles into a transmission
    check("pre_overrun_clear", ovr1, 1'b0);
    s = rand_str();
    push_exp(1, s);
    ascii1 = s; rdy1 = 1'b1;
    @(negedge clk);
    rdy1 = 1'b0;
    repeat (298) @(negedge clk);
    ascii1 = rand_str(); rdy1 = 1'b1;
    @(negedge clk);
    check("overrun_set", ovr1, 1'b1);
    check("overrun_busy", busy1, 1'b1);
    rdy1 = 1'b0;
    wait_idle(1);
    repeat (50) @(negedge clk);
    check("overrun_no_second", busy1, 1'b0);

    check("exp_q1_drained", 64'(exp_q1.size()), 64'd0);
    check("exp_q0_drained", 64'(exp_q0.size()), 64'd0);
    check("blen_q1_drained", 64'(blen_q1.size()), 64'd0);
    check("blen_q0_drained", 64'(blen_q0.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
